// File: rtl/ucsbece154b_gshare_ras_predictor.sv
// Fetch-stage predictor: 2-way BTB with per-set LRU, gshare PHT, speculative GHR with
// mispredict recovery, and a return-address stack. Predictions are combinational on pc_i.
module ucsbece154b_gshare_ras_predictor #(
    parameter  int NUM_BTB_SETS = 16,
    parameter  int GHR_BITS     = 8,
    parameter  int CTR_BITS     = 2,
    parameter  int RAS_DEPTH    = 4,
    localparam int PTR_BITS     = $clog2(RAS_DEPTH),
    localparam int SNAP_BITS    = 2 * PTR_BITS + 1
) (
    input  logic                 clk,
    input  logic                 reset_ni,
    input  logic                 fetch_valid_i,
    input  logic [31:0]          pc_i,
    output logic                 predict_taken_o,
    output logic [31:0]          predict_target_o,
    output logic [GHR_BITS-1:0]  pht_index_o,
    output logic [GHR_BITS-1:0]  ghr_snap_o,
    output logic [SNAP_BITS-1:0] ras_snap_o,
    input  logic                 update_valid_i,
    input  logic [31:0]          update_pc_i,
    input  logic [1:0]           update_type_i,
    input  logic                 update_taken_i,
    input  logic [31:0]          update_target_i,
    input  logic                 update_mispredict_i,
    input  logic [GHR_BITS-1:0]  update_pht_index_i,
    input  logic [GHR_BITS-1:0]  update_ghr_i,
    input  logic [SNAP_BITS-1:0] update_ras_i
);

    localparam int SET_BITS = $clog2(NUM_BTB_SETS);
    localparam int TAG_BITS = 30 - SET_BITS;
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam int PHT_SIZE = 1 << GHR_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(RAS_DEPTH);

    typedef enum logic [1:0] {
        T_BRANCH = 2'd0,
        T_JUMP   = 2'd1,
        T_CALL   = 2'd2,
        T_RETURN = 2'd3
    } ctl_type_e;

    logic                btb_valid  [NUM_BTB_SETS][2];
    logic [TAG_BITS-1:0] btb_tag    [NUM_BTB_SETS][2];
    logic [31:0]         btb_target [NUM_BTB_SETS][2];
    ctl_type_e           btb_type   [NUM_BTB_SETS][2];
    logic                btb_lru    [NUM_BTB_SETS];
    logic [CTR_BITS-1:0] pht        [PHT_SIZE];
    logic [31:0]         ras        [RAS_DEPTH];
    logic [GHR_BITS-1:0] ghr;
    logic [PTR_BITS-1:0] ras_ptr;
    logic [CNT_BITS-1:0] ras_cnt;

    // Fetch-side lookup
    logic [SET_BITS-1:0] f_set;
    logic [TAG_BITS-1:0] f_tag;
    logic                f_hit0, f_hit1, f_hit, f_way, ras_has;
    ctl_type_e           f_type;
    logic [31:0]         f_target, pc_plus4;

    assign f_set    = pc_i[SET_BITS+1:2];
    assign f_tag    = pc_i[31:SET_BITS+2];
    assign f_hit0   = btb_valid[f_set][0] && (btb_tag[f_set][0] == f_tag);
    assign f_hit1   = btb_valid[f_set][1] && (btb_tag[f_set][1] == f_tag);
    assign f_hit    = f_hit0 || f_hit1;
    assign f_way    = ~f_hit0;
    assign f_type   = btb_type[f_set][f_way];
    assign f_target = btb_target[f_set][f_way];
    assign pc_plus4 = pc_i + 32'd4;
    assign ras_has  = (ras_cnt != '0);

    assign pht_index_o = pc_i[GHR_BITS+1:2] ^ ghr;
    assign ghr_snap_o  = ghr;
    assign ras_snap_o  = {ras_ptr, ras_cnt};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        predict_taken_o  = 1'b0;
        predict_target_o = pc_plus4;
        if (f_hit) begin
            case (f_type)
                T_BRANCH: begin
                    predict_taken_o = pht[pht_index_o][CTR_BITS-1];
                    if (predict_taken_o) predict_target_o = f_target;
                end
                T_JUMP, T_CALL: begin
                    predict_taken_o  = 1'b1;
                    predict_target_o = f_target;
                end
                T_RETURN: begin
                    predict_taken_o  = 1'b1;
                    predict_target_o = ras_has ? ras[ras_ptr] : f_target;
                end
                default: ;
            endcase
        end
    end

    // A mispredict flushes the fetch in flight, so its speculative effects are dropped.
    ctl_type_e u_type;
    logic      recover, fetch_act;

    assign u_type    = ctl_type_e'(update_type_i);
    assign recover   = update_valid_i && update_mispredict_i;
    assign fetch_act = fetch_valid_i && !update_mispredict_i && f_hit;

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            ghr <= '0;
        end else if (recover) begin
            ghr <= (u_type == T_BRANCH) ? {update_ghr_i[GHR_BITS-2:0], update_taken_i}
                                        : update_ghr_i;
        end else if (fetch_act && (f_type == T_BRANCH)) begin
            ghr <= {ghr[GHR_BITS-2:0], predict_taken_o};
        end
    end

    // Return-address stack: recovery restores {ptr,count} then replays the resolved op.
    logic [PTR_BITS-1:0] rb_ptr, ras_ptr_n;
    logic [CNT_BITS-1:0] rb_cnt, ras_cnt_n;
    logic                r_push, r_pop;
    logic [31:0]         r_data;

    always_comb begin
        rb_ptr = ras_ptr;
        rb_cnt = ras_cnt;
        r_push = 1'b0;
        r_pop  = 1'b0;
        r_data = pc_plus4;
        if (recover) begin
            {rb_ptr, rb_cnt} = update_ras_i;
            r_push = (u_type == T_CALL);
            r_pop  = (u_type == T_RETURN) && (rb_cnt != '0);
            r_data = update_pc_i + 32'd4;
        end else if (fetch_act) begin
            r_push = (f_type == T_CALL);
            r_pop  = (f_type == T_RETURN) && ras_has;
        end
        ras_ptr_n = rb_ptr;
        ras_cnt_n = rb_cnt;
        if (r_push) begin
            ras_ptr_n = rb_ptr + PTR_BITS'(1);
            ras_cnt_n = (rb_cnt == CNT_FULL) ? rb_cnt : rb_cnt + CNT_BITS'(1);
        end else if (r_pop) begin
            ras_ptr_n = rb_ptr - PTR_BITS'(1);
            ras_cnt_n = rb_cnt - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else begin
            ras_ptr <= ras_ptr_n;
            ras_cnt <= ras_cnt_n;
        end
    end

    // NOTE: RAS data and BTB tag/target/type have no reset; count and valid bits gate their use.
    always_ff @(posedge clk) begin
        if (r_push) ras[ras_ptr_n] <= r_data;
    end

    // Resolved-instruction BTB write
    logic [SET_BITS-1:0] u_set;
    logic [TAG_BITS-1:0] u_tag;
    logic                u_hit0, u_hit1, u_write, u_way;

    assign u_set   = update_pc_i[SET_BITS+1:2];
    assign u_tag   = update_pc_i[31:SET_BITS+2];
    assign u_hit0  = btb_valid[u_set][0] && (btb_tag[u_set][0] == u_tag);
    assign u_hit1  = btb_valid[u_set][1] && (btb_tag[u_set][1] == u_tag);
    assign u_write = update_valid_i && (update_taken_i || (u_type != T_BRANCH));

    always_comb begin
        if (u_hit0)                    u_way = 1'b0;
        else if (u_hit1)               u_way = 1'b1;
        else if (!btb_valid[u_set][0]) u_way = 1'b0;
        else if (!btb_valid[u_set][1]) u_way = 1'b1;
        else                           u_way = btb_lru[u_set];
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int s = 0; s < NUM_BTB_SETS; s++) begin
                btb_valid[s][0] <= 1'b0;
                btb_valid[s][1] <= 1'b0;
                btb_lru[s]      <= 1'b0;
            end
        end else begin
            // The update write comes last so it wins a same-set LRU collision.
            if (fetch_act) btb_lru[f_set] <= ~f_way;
            if (u_write) begin
                btb_valid[u_set][u_way] <= 1'b1;
                btb_lru[u_set]          <= ~u_way;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (u_write) begin
            btb_tag[u_set][u_way]    <= u_tag;
            btb_target[u_set][u_way] <= update_target_i;
            btb_type[u_set][u_way]   <= u_type;
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < PHT_SIZE; i++) pht[i] <= CTR_INIT;
        end else if (update_valid_i && (u_type == T_BRANCH)) begin
            if (update_taken_i && (pht[update_pht_index_i] != CTR_MAX))
                pht[update_pht_index_i] <= pht[update_pht_index_i] + CTR_BITS'(1);
            else if (!update_taken_i && (pht[update_pht_index_i] != '0))
                pht[update_pht_index_i] <= pht[update_pht_index_i] - CTR_BITS'(1);
        end
    end

    // Instruction-alignment bits carry no prediction information.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, pc_i[1:0], update_pc_i[1:0]};

endmodule

// File: tb/tb_ucsbece154b_gshare_ras_predictor.sv
// Directed bench for the gshare/RAS predictor: reset, BTB allocation and LRU,
// PHT saturation, GHR recovery, RAS push/pop/replay and asynchronous reset.
module tb_ucsbece154b_gshare_ras_predictor;

    localparam logic [1:0] BR = 2'd0, JMP = 2'd1, CALL = 2'd2, RET = 2'd3;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        fetch_valid_i;
    logic [31:0] pc_i;
    logic        predict_taken_o;
    logic [31:0] predict_target_o;
    logic [7:0]  pht_index_o, ghr_snap_o;
    logic [4:0]  ras_snap_o;
    logic        update_valid_i;
    logic [31:0] update_pc_i;
    logic [1:0]  update_type_i;
    logic        update_taken_i;
    logic [31:0] update_target_i;
    logic        update_mispredict_i;
    logic [7:0]  update_pht_index_i, update_ghr_i;
    logic [4:0]  update_ras_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ucsbece154b_gshare_ras_predictor #(
        .NUM_BTB_SETS(16), .GHR_BITS(8), .CTR_BITS(2), .RAS_DEPTH(4)
    ) dut (
        .clk                (clk),
        .reset_ni           (reset_ni),
        .fetch_valid_i      (fetch_valid_i),
        .pc_i               (pc_i),
        .predict_taken_o    (predict_taken_o),
        .predict_target_o   (predict_target_o),
        .pht_index_o        (pht_index_o),
        .ghr_snap_o         (ghr_snap_o),
        .ras_snap_o         (ras_snap_o),
        .update_valid_i     (update_valid_i),
        .update_pc_i        (update_pc_i),
        .update_type_i      (update_type_i),
        .update_taken_i     (update_taken_i),
        .update_target_i    (update_target_i),
        .update_mispredict_i(update_mispredict_i),
        .update_pht_index_i (update_pht_index_i),
        .update_ghr_i       (update_ghr_i),
        .update_ras_i       (update_ras_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_valid_i       = 1'b0;
        pc_i                = 32'h0;
        update_valid_i      = 1'b0;
        update_pc_i         = 32'h0;
        update_type_i       = BR;
        update_taken_i      = 1'b0;
        update_target_i     = 32'h0;
        update_mispredict_i = 1'b0;
        update_pht_index_i  = 8'h0;
        update_ghr_i        = 8'h0;
        update_ras_i        = 5'h0;
    endtask

    task automatic apply_reset();
        idle();
        reset_ni = 1'b0;
        tick();
        tick();
        reset_ni = 1'b1;
        #1;
    endtask

    // One-cycle update; fetch inputs are left as the caller set them.
    task automatic upd(input logic [1:0] t, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic mp, input logic [7:0] idx,
                       input logic [7:0] gh, input logic [4:0] rs);
        update_valid_i      = 1'b1;
        update_type_i       = t;
        update_pc_i         = pc;
        update_target_i     = tgt;
        update_taken_i      = tk;
        update_mispredict_i = mp;
        update_pht_index_i  = idx;
        update_ghr_i        = gh;
        update_ras_i        = rs;
        tick();
        update_valid_i      = 1'b0;
        update_mispredict_i = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        fetch_valid_i = 1'b0;
        pc_i          = pc;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        fetch_valid_i = 1'b1;
        pc_i          = 32'h100;
        #1;
        total++; if (predict_taken_o !== 1'b0) begin bad++; $display("FAIL reset_taken got=%0d exp=0", predict_taken_o); end
        total++; if (predict_target_o !== 32'h104) begin bad++; $display("FAIL reset_target got=%h exp=00000104", predict_target_o); end
        total++; if (pht_index_o !== 8'h40) begin bad++; $display("FAIL reset_pht_index got=%h exp=40", pht_index_o); end
        total++; if (ghr_snap_o !== 8'h00 || ras_snap_o !== 5'h00) begin bad++; $display("FAIL reset_snaps ghr=%h ras=%h exp=00/00", ghr_snap_o, ras_snap_o); end
        tick();
        fetch_valid_i = 1'b0;
    endtask

    task automatic test_btb_alloc();
        apply_reset();
        upd(JMP, 32'h100, 32'h200, 1'b1, 1'b0, 8'h0, 8'h0, 5'h0);
        look(32'h100);
        total++; if (predict_taken_o !== 1'b1 || predict_target_o !== 32'h200) begin bad++; $display("FAIL jump_alloc got=%0d/%h exp=1/00000200", predict_taken_o, predict_target_o); end
        upd(JMP, 32'h100, 32'h240, 1'b1, 1'b0, 8'h0, 8'h0, 5'h0);
        look(32'h100);
        total++; if (predict_target_o !== 32'h240) begin bad++; $display("FAIL jump_overwrite got=%h exp=00000240", predict_target_o); end
        // Raise PHT[0x18] to strongly taken, then a not-taken branch mapping there must not allocate.
        upd(BR, 32'h2000, 32'h3000, 1'b1, 1'b0, 8'h18, 8'h0, 5'h0);
        upd(BR, 32'h2000, 32'h3000, 1'b1, 1'b0, 8'h18, 8'h0, 5'h0);
        upd(BR, 32'h60, 32'h900, 1'b0, 1'b0, 8'h18, 8'h0, 5'h0);
        look(32'h60);
        total++; if (predict_taken_o !== 1'b0 || predict_target_o !== 32'h64) begin bad++; $display("FAIL nt_no_alloc got=%0d/%h exp=0/00000064", predict_taken_o, predict_target_o); end
    endtask

    task automatic test_lru();
        apply_reset();
        upd(JMP, 32'h100, 32'h1100, 1'b1, 1'b0, 8'h0, 8'h0, 5'h0);
        upd(JMP, 32'h140, 32'h1140, 1'b1, 1'b0, 8'h0, 8'h0, 5'h0);
        fetch_valid_i = 1'b1;
        pc_i          = 32'h140;
        tick();
        fetch_valid_i = 1'b0;
        upd(JMP, 32'h180, 32'h1180, 1'b1, 1'b0, 8'h0, 8'h0, 5'h0);
        look(32'h100);
        total++; if (predict_taken_o !== 1'b0 || predict_target_o !== 32'h104) begin bad++; $display("FAIL lru_evict_100 got=%0d/%h exp=0/00000104", predict_taken_o, predict_target_o); end
        look(32'h180);
        total++; if (predict_taken_o !== 1'b1 || predict_target_o !== 32'h1180) begin bad++; $display("FAIL lru_keep_180 got=%0d/%h exp=1/00001180", predict_taken_o, predict_target_o); end
        look(32'h140);
        total++; if (predict_taken_o !== 1'b1 || predict_target_o !== 32'h1140) begin bad++; $display("FAIL lru_keep_140 got=%0d/%h exp=1/00001140", predict_taken_o, predict_target_o); end

        // Fetch hit on way0 and update hit on way1 in the same set: update's LRU choice stands.
        apply_reset();
        upd(JMP, 32'h100, 32'h1100, 1'b1, 1'b0, 8'h0, 8'h0, 5'h0);
        upd(JMP, 32'h140, 32'h1140, 1'b1, 1'b0, 8'h0, 8'h0, 5'h0);
        fetch_valid_i = 1'b1;
        pc_i          = 32'h100;
        upd(JMP, 32'h140, 32'h2140, 1'b1, 1'b0, 8'h0, 8'h0, 5'h0);
        fetch_valid_i = 1'b0;
        upd(JMP, 32'h180, 32'h1180, 1'b1, 1'b0, 8'h0, 8'h0, 5'h0);
        look(32'h100);
        total++; if (predict_taken_o !== 1'b0) begin bad++; $display("FAIL lru_conflict_100 got=%0d exp=0", predict_taken_o); end
        look(32'h140);
        total++; if (predict_taken_o !== 1'b1 || predict_target_o !== 32'h2140) begin bad++; $display("FAIL lru_conflict_140 got=%0d/%h exp=1/00002140", predict_taken_o, predict_target_o); end
    endtask

    task automatic test_pht();
        apply_reset();
        upd(BR, 32'h40, 32'h80, 1'b1, 1'b0, 8'h10, 8'h0, 5'h0);   // 01 -> 10
        look(32'h40);
        total++; if (pht_index_o !== 8'h10) begin bad++; $display("FAIL pht_index got=%h exp=10", pht_index_o); end
        total++; if (predict_taken_o !== 1'b1 || predict_target_o !== 32'h80) begin bad++; $display("FAIL pht_10 got=%0d/%h exp=1/00000080", predict_taken_o, predict_target_o); end
        upd(BR, 32'h40, 32'h80, 1'b1, 1'b0, 8'h10, 8'h0, 5'h0);   // 11
        upd(BR, 32'h40, 32'h80, 1'b1, 1'b0, 8'h10, 8'h0, 5'h0);   // 11 held
        upd(BR, 32'h40, 32'h80, 1'b0, 1'b0, 8'h10, 8'h0, 5'h0);   // 10
        look(32'h40);
        total++; if (predict_taken_o !== 1'b1) begin bad++; $display("FAIL pht_sat_hi got=%0d exp=1", predict_taken_o); end
        upd(BR, 32'h40, 32'h80, 1'b0, 1'b0, 8'h10, 8'h0, 5'h0);   // 01
        look(32'h40);
        total++; if (predict_taken_o !== 1'b0 || predict_target_o !== 32'h44) begin bad++; $display("FAIL pht_01 got=%0d/%h exp=0/00000044", predict_taken_o, predict_target_o); end
        upd(BR, 32'h40, 32'h80, 1'b0, 1'b0, 8'h10, 8'h0, 5'h0);   // 00
        upd(BR, 32'h40, 32'h80, 1'b0, 1'b0, 8'h10, 8'h0, 5'h0);   // 00 held
        upd(BR, 32'h40, 32'h80, 1'b1, 1'b0, 8'h10, 8'h0, 5'h0);   // 01
        look(32'h40);
        total++; if (predict_taken_o !== 1'b0) begin bad++; $display("FAIL pht_sat_lo got=%0d exp=0", predict_taken_o); end
        upd(BR, 32'h40, 32'h80, 1'b1, 1'b0, 8'h10, 8'h0, 5'h0);   // 10
        look(32'h40);
        total++; if (predict_taken_o !== 1'b1) begin bad++; $display("FAIL pht_recover got=%0d exp=1", predict_taken_o); end
    endtask

    task automatic test_ghr();
        apply_reset();
        // Mispredicted taken branch with snapshot 0x07 sets GHR to 0x0F and PHT[0x1F] to 10.
        upd(BR, 32'h40, 32'h80, 1'b1, 1'b1, 8'h1F, 8'h07, 5'h0);
        look(32'h40);
        total++; if (ghr_snap_o !== 8'h0F || pht_index_o !== 8'h1F) begin bad++; $display("FAIL ghr_recover_br ghr=%h idx=%h exp=0f/1f", ghr_snap_o, pht_index_o); end
        total++; if (predict_taken_o !== 1'b1 || predict_target_o !== 32'h80) begin bad++; $display("FAIL ghr_pred got=%0d/%h exp=1/00000080", predict_taken_o, predict_target_o); end
        fetch_valid_i = 1'b1;
        upd(BR, 32'h44, 32'h0, 1'b0, 1'b1, 8'h00, 8'h03, 5'h0);
        fetch_valid_i = 1'b0;
        #1;
        total++; if (ghr_snap_o !== 8'h06) begin bad++; $display("FAIL ghr_mispredict_override got=%h exp=06", ghr_snap_o); end
        fetch_valid_i = 1'b1;
        #1;
        total++; if (predict_taken_o !== 1'b0) begin bad++; $display("FAIL ghr_pred_nt got=%0d exp=0", predict_taken_o); end
        tick();
        fetch_valid_i = 1'b0;
        total++; if (ghr_snap_o !== 8'h0C) begin bad++; $display("FAIL ghr_shift_nt got=%h exp=0c", ghr_snap_o); end
        upd(JMP, 32'h500, 32'h600, 1'b1, 1'b1, 8'h00, 8'h5A, 5'h0);
        total++; if (ghr_snap_o !== 8'h5A) begin bad++; $display("FAIL ghr_recover_jmp got=%h exp=5a", ghr_snap_o); end
        upd(BR, 32'h40, 32'h80, 1'b1, 1'b0, 8'h4A, 8'h00, 5'h0);
        fetch_valid_i = 1'b1;
        pc_i          = 32'h40;
        tick();
        fetch_valid_i = 1'b0;
        total++; if (ghr_snap_o !== 8'hB5) begin bad++; $display("FAIL ghr_shift_t got=%h exp=b5", ghr_snap_o); end
    endtask

    task automatic test_ras();
        logic [31:0] call_pc [5] = '{32'h10, 32'h20, 32'h30, 32'h50, 32'h60};
        logic [31:0] exp_tgt [5] = '{32'h64, 32'h54, 32'h34, 32'h24, 32'h700};
        apply_reset();
        for (int i = 0; i < 5; i++)
            upd(CALL, call_pc[i], 32'h500 + call_pc[i], 1'b1, 1'b0, 8'h0, 8'h0, 5'h0);
        upd(RET, 32'h300, 32'h700, 1'b1, 1'b0, 8'h0, 8'h0, 5'h0);
        fetch_valid_i = 1'b1;
        pc_i          = 32'h10;
        #1;
        total++; if (predict_taken_o !== 1'b1 || predict_target_o !== 32'h510) begin bad++; $display("FAIL call_pred got=%0d/%h exp=1/00000510", predict_taken_o, predict_target_o); end
        tick();
        pc_i = 32'h300;
        #1;
        total++; if (ras_snap_o !== {2'd1, 3'd1}) begin bad++; $display("FAIL ras_after_push got=%h exp=09", ras_snap_o); end
        total++; if (predict_taken_o !== 1'b1 || predict_target_o !== 32'h14) begin bad++; $display("FAIL ret_pred got=%0d/%h exp=1/00000014", predict_taken_o, predict_target_o); end
        tick();
        look(32'h300);
        total++; if (predict_target_o !== 32'h700 || ras_snap_o !== 5'h00) begin bad++; $display("FAIL ret_empty got=%h ras=%h exp=00000700/00", predict_target_o, ras_snap_o); end

        // Five calls overflow a depth-4 stack; five returns pop four then fall back to the BTB.
        fetch_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc_i = call_pc[i];
            tick();
        end
        total++; if (ras_snap_o !== {2'd1, 3'd4}) begin bad++; $display("FAIL ras_full got=%h exp=0c", ras_snap_o); end
        pc_i = 32'h300;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (predict_taken_o !== 1'b1 || predict_target_o !== exp_tgt[i]) begin bad++; $display("FAIL ret_pop%0d got=%0d/%h exp=1/%h", i, predict_taken_o, predict_target_o, exp_tgt[i]); end
            tick();
        end

        // Mispredicted call replays its push on the restored pointer; the concurrent fetch call is dropped.
        pc_i = 32'h10;
        upd(CALL, 32'h80, 32'h900, 1'b1, 1'b1, 8'h0, 8'h0, {2'd2, 3'd1});
        look(32'h300);
        total++; if (ras_snap_o !== {2'd3, 3'd2}) begin bad++; $display("FAIL ras_replay_call got=%h exp=1a", ras_snap_o); end
        total++; if (predict_target_o !== 32'h84) begin bad++; $display("FAIL ras_replay_top got=%h exp=00000084", predict_target_o); end
        upd(RET, 32'h300, 32'h700, 1'b1, 1'b1, 8'h0, 8'h0, {2'd3, 3'd2});
        look(32'h300);
        total++; if (ras_snap_o !== {2'd2, 3'd1} || predict_target_o !== 32'h24) begin bad++; $display("FAIL ras_replay_ret got=%h/%h exp=11/00000024", ras_snap_o, predict_target_o); end
    endtask

    task automatic test_async_reset();
        look(32'h10);
        total++; if (predict_taken_o !== 1'b1) begin bad++; $display("FAIL pre_reset_hit got=%0d exp=1", predict_taken_o); end
        #2 reset_ni = 1'b0;
        #1;
        total++; if (predict_taken_o !== 1'b0 || predict_target_o !== 32'h14 || ras_snap_o !== 5'h0 || ghr_snap_o !== 8'h0) begin bad++; $display("FAIL async_reset got=%0d/%h ras=%h ghr=%h exp=0/00000014/00/00", predict_taken_o, predict_target_o, ras_snap_o, ghr_snap_o); end
        tick();
        reset_ni = 1'b1;
        tick();
        look(32'h300);
        total++; if (predict_taken_o !== 1'b0 || predict_target_o !== 32'h304) begin bad++; $display("FAIL post_reset_miss got=%0d/%h exp=0/00000304", predict_taken_o, predict_target_o); end
    endtask

    initial begin
        reset_ni = 1'b0;
        idle();
        test_reset();
        test_btb_alloc();
        test_lru();
        test_pht();
        test_ghr();
        test_ras();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
